// File: rtl/ex_stage.sv
// Execute stage: decodes the ALU control at accept, drives an external ALU from a one-entry
// issue register, and buffers ALU results in a small FIFO towards EX/MEM.
module ex_stage #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned OBUF_DEPTH = 3
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            alu_src,
    input  logic            branch,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_operation,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_overflow,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_zero,
    output logic            out_overflow,
    output logic            out_branch_taken,
    output logic            out_illegal
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;

    localparam logic [1:0] LastIdx = 2'(OBUF_DEPTH - 1);
    localparam logic [2:0] DepthW  = 3'(OBUF_DEPTH);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic            zero;
        logic            overflow;
        logic            branch_taken;
        logic            illegal;
    } obuf_entry_t;

    // Issue register
    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] store_q, store_d;
    logic            branch_q, branch_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            illegal_q, illegal_d;

    // Output buffer
    obuf_entry_t     obuf_q [OBUF_DEPTH];
    obuf_entry_t     obuf_d [OBUF_DEPTH];
    logic [1:0]      wptr_q, wptr_d;
    logic [1:0]      rptr_q, rptr_d;
    logic [1:0]      count_q, count_d;

    logic            exec;
    logic            accept;
    logic            push;
    logic            pop;
    logic [3:0]      dec_op;
    logic            dec_illegal;
    logic            taken;
    obuf_entry_t     new_entry;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LastIdx) ? 2'd0 : p + 2'd1;
    endfunction

    // Main decoder for the ALU control
    always_comb begin
        dec_op      = OpAdd;
        dec_illegal = 1'b0;
        unique case (alu_op)
            2'b00: dec_op = OpAdd;
            2'b01: dec_op = OpSub;
            2'b10: begin
                case (funct3)
                    3'b000:  dec_op = (funct7_5 && !alu_src) ? OpSub : OpAdd;
                    3'b111:  dec_op = OpAnd;
                    3'b110:  dec_op = OpOr;
                    3'b010:  dec_op = OpSlt;
                    default: begin
                        dec_op      = OpAdd;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            2'b11: begin
                dec_op      = OpAdd;
                dec_illegal = 1'b1;
            end
            default: dec_op = OpAdd;
        endcase
        // Only BEQ/BNE are supported branch conditions
        if (branch && (funct3[2:1] != 2'b00)) begin
            dec_illegal = 1'b1;
        end
    end

    // Registered-state-only ready: no path from out_ready
    always_comb begin
        exec     = (state_q == StExec);
        in_ready = (({1'b0, count_q} + {2'b00, exec}) < DepthW);
        accept   = in_valid && in_ready;
    end

    // Issue register next state; cleared whenever nothing is accepted so the ALU sees zeros
    always_comb begin
        state_d   = StIdle;
        op_d      = '0;
        a_d       = '0;
        b_d       = '0;
        store_d   = '0;
        branch_d  = 1'b0;
        funct3_d  = '0;
        illegal_d = 1'b0;
        if (accept) begin
            state_d   = StExec;
            op_d      = dec_op;
            a_d       = rs1_data;
            b_d       = alu_src ? imm : rs2_data;
            store_d   = rs2_data;
            branch_d  = branch;
            funct3_d  = funct3;
            illegal_d = dec_illegal;
        end
    end

    always_comb begin
        alu_a         = a_q;
        alu_b         = b_q;
        alu_operation = op_q;
    end

    always_comb begin
        taken = 1'b0;
        if (branch_q) begin
            if (funct3_q == 3'b000) begin
                taken = alu_zero;
            end else if (funct3_q == 3'b001) begin
                taken = !alu_zero;
            end
        end
        new_entry.result       = alu_result;
        new_entry.store_data   = store_q;
        new_entry.zero         = alu_zero;
        new_entry.overflow     = alu_overflow;
        new_entry.branch_taken = taken;
        new_entry.illegal      = illegal_q;
    end

    // Output FIFO; a push never finds it full because in_ready reserves a slot for EXEC
    always_comb begin
        push = exec;
        pop  = out_valid && out_ready;
        for (int i = 0; i < OBUF_DEPTH; i++) begin
            obuf_d[i] = obuf_q[i];
        end
        if (push) begin
            obuf_d[wptr_q] = new_entry;
        end
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        out_valid        = (count_q != 2'd0);
        out_result       = obuf_q[rptr_q].result;
        out_store_data   = obuf_q[rptr_q].store_data;
        out_zero         = obuf_q[rptr_q].zero;
        out_overflow     = obuf_q[rptr_q].overflow;
        out_branch_taken = obuf_q[rptr_q].branch_taken;
        out_illegal      = obuf_q[rptr_q].illegal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            store_q   <= '0;
            branch_q  <= 1'b0;
            funct3_q  <= '0;
            illegal_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                obuf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            store_q   <= store_d;
            branch_q  <= branch_d;
            funct3_q  <= funct3_d;
            illegal_q <= illegal_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                obuf_q[i] <= obuf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: behavioural ALU, queue-based reference model with a per-cycle compare
// process, directed literal checks and a randomized phase.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5, alu_src, branch;
    logic [63:0] rs1_data, rs2_data, imm;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_operation;
    logic        alu_zero, alu_overflow;
    logic        out_valid, out_ready;
    logic [63:0] out_result, out_store_data;
    logic        out_zero, out_overflow, out_branch_taken, out_illegal;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(64), .OBUF_DEPTH(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .alu_src(alu_src),
        .branch(branch), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_zero(out_zero),
        .out_overflow(out_overflow), .out_branch_taken(out_branch_taken),
        .out_illegal(out_illegal)
    );

    function automatic logic [63:0] alu_res(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic alu_ovf(input logic [3:0] op, input logic [63:0] a,
                                     input logic [63:0] b);
        logic [63:0] s;
        s = alu_res(op, a, b);
        if (op == 4'b0010) return (a[63] == b[63]) && (s[63] != a[63]);
        if (op == 4'b0110) return (a[63] != b[63]) && (s[63] != a[63]);
        return 1'b0;
    endfunction

    always_comb begin
        alu_result   = alu_res(alu_operation, alu_a, alu_b);
        alu_overflow = alu_ovf(alu_operation, alu_a, alu_b);
        alu_zero     = (alu_result == 64'd0);
    end

    typedef struct {
        logic [63:0] res;
        logic [63:0] store;
        logic        zero;
        logic        ovf;
        logic        taken;
        logic        ill;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        int          rdy;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the stage must produce for one accepted instruction
    function automatic exp_t ref_op(input logic [1:0] aop, input logic [2:0] f3, input logic f75,
                                    input logic src, input logic br, input logic [63:0] r1,
                                    input logic [63:0] r2, input logic [63:0] im);
        exp_t e;
        e.op  = 4'b0010;
        e.ill = 1'b0;
        if (aop == 2'b01) e.op = 4'b0110;
        else if (aop == 2'b11) e.ill = 1'b1;
        else if (aop == 2'b10) begin
            if (f3 == 3'd0) e.op = (f75 && !src) ? 4'b0110 : 4'b0010;
            else if (f3 == 3'd7) e.op = 4'b0000;
            else if (f3 == 3'd6) e.op = 4'b0001;
            else if (f3 == 3'd2) e.op = 4'b0111;
            else e.ill = 1'b1;
        end
        if (br && f3 > 3'd1) e.ill = 1'b1;
        e.a     = r1;
        e.b     = src ? im : r2;
        e.store = r2;
        e.res   = alu_res(e.op, e.a, e.b);
        e.ovf   = alu_ovf(e.op, e.a, e.b);
        e.zero  = (e.res == 64'd0);
        e.taken = br && ((f3 == 3'd0 && e.zero) || (f3 == 3'd1 && !e.zero));
        e.rdy   = 0;
        return e;
    endfunction

    exp_t        mq[$];
    logic [63:0] popped[$];
    int          cyc = 0;
    bit          armed = 1'b0;
    bit          m_ev, m_er;
    int          m_ex;
    exp_t        m_e;

    // Compare process: ops in flight = accepted and not yet popped; visible 2 cycles after accept
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete();
            armed = 1'b1;
        end else if (armed) begin
            m_ev = (mq.size() > 0) && (mq[0].rdy <= cyc);
            m_er = (mq.size() < 3);
            chk("m_out_valid", out_valid, m_ev);
            chk("m_in_ready", in_ready, m_er);
            if (m_ev) begin
                chk("m_result", out_result, mq[0].res);
                chk("m_store", out_store_data, mq[0].store);
                chk("m_zero", out_zero, mq[0].zero);
                chk("m_ovf", out_overflow, mq[0].ovf);
                chk("m_taken", out_branch_taken, mq[0].taken);
                chk("m_illegal", out_illegal, mq[0].ill);
            end
            m_ex = -1;
            foreach (mq[i]) if (mq[i].rdy == cyc + 1) m_ex = i;
            if (m_ex >= 0) begin
                chk("m_alu_op", alu_operation, mq[m_ex].op);
                chk("m_alu_a", alu_a, mq[m_ex].a);
                chk("m_alu_b", alu_b, mq[m_ex].b);
            end else begin
                chk("m_alu_op_idle", alu_operation, 0);
                chk("m_alu_a_idle", alu_a, 0);
                chk("m_alu_b_idle", alu_b, 0);
            end
            if (m_ev && out_ready) begin
                popped.push_back(mq[0].res);
                mq.delete(0);
            end
            if (in_valid && m_er) begin
                m_e = ref_op(alu_op, funct3, funct7_5, alu_src, branch, rs1_data, rs2_data, imm);
                m_e.rdy = cyc + 2;
                mq.push_back(m_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] aop, input logic [2:0] f3, input logic f75,
                          input logic src, input logic br, input logic [63:0] r1,
                          input logic [63:0] r2, input logic [63:0] im);
        alu_op = aop; funct3 = f3; funct7_5 = f75; alu_src = src; branch = br;
        rs1_data = r1; rs2_data = r2; imm = im; in_valid = 1'b1;
    endtask

    task automatic rand_op();
        logic [63:0] r1, r2;
        r1 = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       r2 = r1;
            1:       r2 = 64'($urandom_range(0, 3));
            default: r2 = {$urandom, $urandom};
        endcase
        set_op(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), r1, r2, {$urandom, $urandom});
    endtask

    initial begin
        int mark, w, acc_n, first, val_n;
        bit acc;
        in_valid = 1'b0; out_ready = 1'b1;
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_operation", alu_operation, 0);
        chk("rst_out_result", out_result, 0);
        reset = 1'b0;

        // ADD 5 + 7
        set_op(2'b10, 3'b000, 0, 0, 0, 64'd5, 64'd7, 0);
        @(negedge clk); chk("add_in_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        @(negedge clk); chk("add_alu_operation", alu_operation, 4'b0010);
        chk("add_valid_early", out_valid, 0);
        tick();
        @(negedge clk); chk("add_valid", out_valid, 1); chk("add_result", out_result, 12);
        chk("add_zero", out_zero, 0);
        tick();

        // BEQ then BNE on equal operands
        set_op(2'b01, 3'b000, 0, 0, 1, 64'h1234, 64'h1234, 0);
        tick(); in_valid = 1'b0;
        @(negedge clk); chk("beq_alu_operation", alu_operation, 4'b0110);
        tick();
        @(negedge clk); chk("beq_zero", out_zero, 1); chk("beq_taken", out_branch_taken, 1);
        chk("beq_illegal", out_illegal, 0);
        tick();
        set_op(2'b01, 3'b001, 0, 0, 1, 64'h1234, 64'h1234, 0);
        tick(); in_valid = 1'b0;
        tick();
        @(negedge clk); chk("bne_zero", out_zero, 1); chk("bne_taken", out_branch_taken, 0);
        tick();

        // Illegal funct3, then OR with immediate
        set_op(2'b10, 3'b101, 0, 0, 0, 64'd3, 64'd4, 0);
        tick(); in_valid = 1'b0;
        @(negedge clk); chk("ill_alu_operation", alu_operation, 4'b0010);
        tick();
        @(negedge clk); chk("ill_flag", out_illegal, 1); chk("ill_result", out_result, 7);
        tick();
        set_op(2'b10, 3'b110, 0, 1, 0, 64'h0F, 64'h55, 64'hF0);
        tick(); in_valid = 1'b0;
        @(negedge clk); chk("or_alu_operation", alu_operation, 4'b0001);
        tick();
        @(negedge clk); chk("or_result", out_result, 64'hFF); chk("or_illegal", out_illegal, 0);
        tick();

        // Back-pressure: three accepts fill the stage, the fourth waits
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op(2'b00, 3'b000, 0, 0, 0, 64'((i + 1) * 10), 0, 0);
            @(negedge clk);
            if (i < 3) chk("bp_ready", in_ready, 1);
            else chk("bp_stall", in_ready, 0);
            tick();
        end
        repeat (2) begin
            @(negedge clk); chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1); chk("bp_hold_result", out_result, 10);
            tick();
        end
        mark = popped.size();
        out_ready = 1'b1;
        w = 0; acc = 1'b0;
        while (!acc && w < 20) begin
            @(negedge clk); acc = in_ready; tick(); w++;
        end
        chk("bp_4th_accepted", acc, 1);
        chk("bp_4th_wait", w, 2);
        in_valid = 1'b0;
        repeat (6) tick();
        chk("bp_pop_count", popped.size() - mark, 4);
        for (int i = 0; i < 4; i++) begin
            if (mark + i < popped.size()) chk("bp_order", popped[mark + i], 64'((i + 1) * 10));
        end

        // Reset with two entries buffered and EXEC busy
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(2'b00, 3'b000, 0, 0, 0, 64'(100 + i), 64'd1, 0);
            tick();
        end
        set_op(2'b00, 3'b000, 0, 0, 0, 64'd77, 64'd1, 0);
        reset = 1'b1;
        @(negedge clk); chk("rm_pre_valid", out_valid, 1);
        chk("rm_pre_alu_operation", alu_operation, 4'b0010);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk); chk("rm_valid", out_valid, 0); chk("rm_in_ready", in_ready, 1);
        chk("rm_alu_operation", alu_operation, 0);
        out_ready = 1'b1;
        val_n = 0;
        repeat (5) begin
            tick(); @(negedge clk); if (out_valid) val_n++;
        end
        chk("rm_no_stale", val_n, 0);
        tick();

        // Full throughput
        acc_n = 0; first = -1; val_n = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 10) rand_op();
            else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) acc_n++;
            if (out_valid) begin
                val_n++;
                if (first < 0) first = i;
            end
            tick();
        end
        chk("tp_accepts", acc_n, 10);
        chk("tp_first_valid", first, 2);
        chk("tp_valid_cycles", val_n, 10);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 500; i++) begin
            rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
